// File: rtl/apb_tick_gen.sv
// APB-programmable tick generator: synchronizes and glitch-filters EXTIN, turns
// selected filtered edges (or every PCLK) into events, and prescales them into TICKOUT pulses.
module apb_tick_gen (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic [11:2] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        EXTIN,
    output logic        TICKOUT,
    output logic        FILTLVL
);

    logic        r_en;
    logic [1:0]  r_src;
    logic [3:0]  r_filt;
    logic [15:0] r_presc;
    logic [15:0] r_cnt;
    logic        r_tick;
    logic        r_tickSeen;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_filtLvl;
    logic        r_filtDly;
    logic [3:0]  r_runCnt;

    logic        w_addrOk;
    logic        w_wrEn;
    logic        w_wrCtrl;
    logic        w_wrFilt;
    logic        w_wrPresc;
    logic        w_wrStatus;
    logic        w_event;
    logic        w_wrap;
    logic        w_unused;

    assign w_addrOk   = (PADDR <= 10'd3);
    assign w_wrEn     = PSEL & PENABLE & PWRITE & w_addrOk;
    assign w_wrCtrl   = w_wrEn & (PADDR == 10'd0);
    assign w_wrFilt   = w_wrEn & (PADDR == 10'd1);
    assign w_wrPresc  = w_wrEn & (PADDR == 10'd2);
    assign w_wrStatus = w_wrEn & (PADDR == 10'd3);
    assign w_unused   = ^PWDATA[31:16];

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & ~w_addrOk;
    assign TICKOUT = r_tick;
    assign FILTLVL = r_filtLvl;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_en    <= 1'b0;
            r_src   <= 2'b00;
            r_filt  <= 4'd0;
            r_presc <= 16'd0;
        end else begin
            if (w_wrCtrl) begin
                r_en  <= PWDATA[0];
                r_src <= PWDATA[2:1];
            end
            if (w_wrFilt) begin
                r_filt <= PWDATA[3:0];
            end
            if (w_wrPresc) begin
                r_presc <= PWDATA[15:0];
            end
        end
    end

    // Synchronizer and filter run even while disabled, so enabling never sees a stale edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_filtLvl <= 1'b0;
            r_filtDly <= 1'b0;
            r_runCnt  <= 4'd0;
        end else begin
            r_sync1   <= EXTIN;
            r_sync2   <= r_sync1;
            r_filtDly <= r_filtLvl;
            if (w_wrFilt) begin
                r_runCnt <= 4'd0;
            end else if (r_sync2 != r_filtLvl) begin
                if (r_runCnt == r_filt) begin
                    r_filtLvl <= r_sync2;
                    r_runCnt  <= 4'd0;
                end else begin
                    r_runCnt <= r_runCnt + 4'd1;
                end
            end else begin
                r_runCnt <= 4'd0;
            end
        end
    end

    always_comb begin
        w_event = 1'b0;
        case (r_src)
            2'b00:   w_event = r_filtLvl & ~r_filtDly;
            2'b01:   w_event = ~r_filtLvl & r_filtDly;
            2'b10:   w_event = r_filtLvl ^ r_filtDly;
            default: w_event = 1'b1;
        endcase
    end

    // A CTRL/PRESC write restarts the prescaler and swallows any event of that cycle.
    assign w_wrap = r_en & w_event & ~(w_wrCtrl | w_wrPresc) & (r_cnt == r_presc);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt      <= 16'd0;
            r_tick     <= 1'b0;
            r_tickSeen <= 1'b0;
        end else begin
            if (w_wrCtrl | w_wrPresc | ~r_en) begin
                r_cnt <= 16'd0;
            end else if (w_event) begin
                r_cnt <= (r_cnt == r_presc) ? 16'd0 : r_cnt + 16'd1;
            end
            r_tick <= w_wrap;
            if (w_wrap | r_tick) begin
                r_tickSeen <= 1'b1;
            end else if (w_wrStatus & PWDATA[0]) begin
                r_tickSeen <= 1'b0;
            end
        end
    end

    always_comb begin
        PRDATA = 32'd0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                10'd0:   PRDATA = {29'd0, r_src, r_en};
                10'd1:   PRDATA = {28'd0, r_filt};
                10'd2:   PRDATA = {16'd0, r_presc};
                10'd3:   PRDATA = {r_cnt, 15'd0, r_tickSeen};
                default: PRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_tick_gen.sv
// Directed bench for apb_tick_gen: register vector table plus multi-cycle
// sequences for filtering, prescaling, counter restart, W1C races and reset.
module tb_apb_tick_gen;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL;
    logic [9:0]  PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        EXTIN;
    logic        TICKOUT;
    logic        FILTLVL;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
    } apbVec_t;

    apb_tick_gen dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .EXTIN(EXTIN), .TICKOUT(TICKOUT),
        .FILTLVL(FILTLVL)
    );

    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows the access edge.
    task automatic applyStimulus(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err);
        PSEL = 1'b1; PWRITE = wr; PADDR = addr; PWDATA = wdata; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        rdata = PRDATA;
        err   = PSLVERR;
        checkOutput($sformatf("pready_a%0d", addr), {31'd0, PREADY}, 32'd1);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apbWrite(input logic [9:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic        e;
        applyStimulus(1'b1, addr, wdata, rd, e);
    endtask

    task automatic settle(input int n);
        EXTIN = 1'b0;
        repeat (n) @(negedge PCLK);
    endtask

    // Reference model: square wave on EXTIN, F=0, monitoring STATUS combinationally.
    task automatic runModel(input int n, input int period, input logic [1:0] src,
                            input logic [15:0] p, input string tag, output int ticks);
        logic [15:0] cnt = 16'd0;
        logic        p1 = 1'b0, p2 = 1'b0, f1 = 1'b0, f2 = 1'b0;
        logic        pat, fNow, ev, tickExp;
        ticks = 0;
        PSEL = 1'b1; PADDR = 10'd3; PWRITE = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < n; i++) begin
            pat = ((i % period) < (period / 2));
            EXTIN = pat;
            @(negedge PCLK);
            fNow = p2;
            case (src)
                2'b00:   ev = f1 & ~f2;
                2'b01:   ev = ~f1 & f2;
                2'b10:   ev = f1 ^ f2;
                default: ev = 1'b1;
            endcase
            tickExp = 1'b0;
            if (ev) begin
                if (cnt == p) begin
                    cnt = 16'd0;
                    tickExp = 1'b1;
                end else begin
                    cnt = cnt + 16'd1;
                end
            end
            p2 = p1; p1 = pat; f2 = f1; f1 = fNow;
            if (TICKOUT === 1'b1) ticks++;
            checkOutput($sformatf("%s_filt_%0d", tag, i), {31'd0, FILTLVL}, {31'd0, fNow});
            checkOutput($sformatf("%s_tick_%0d", tag, i), {31'd0, TICKOUT}, {31'd0, tickExp});
            checkOutput($sformatf("%s_cnt_%0d", tag, i), {16'd0, PRDATA[31:16]}, {16'd0, cnt});
        end
        PSEL = 1'b0;
    endtask

    initial begin
        apbVec_t     vecs[19];
        logic [31:0] rd;
        logic        err;
        int          ticks;

        vecs[0]  = '{1'b0, 10'd0,   32'h0,        32'h0,    1'b0};
        vecs[1]  = '{1'b0, 10'd1,   32'h0,        32'h0,    1'b0};
        vecs[2]  = '{1'b0, 10'd2,   32'h0,        32'h0,    1'b0};
        vecs[3]  = '{1'b0, 10'd3,   32'h0,        32'h0,    1'b0};
        vecs[4]  = '{1'b1, 10'd2,   32'h12345678, 32'h0,    1'b0};
        vecs[5]  = '{1'b0, 10'd2,   32'h0,        32'h5678, 1'b0};
        vecs[6]  = '{1'b1, 10'd1,   32'hFFFFFFFF, 32'h0,    1'b0};
        vecs[7]  = '{1'b0, 10'd1,   32'h0,        32'hF,    1'b0};
        vecs[8]  = '{1'b1, 10'd0,   32'hFFFFFFF6, 32'h0,    1'b0};
        vecs[9]  = '{1'b0, 10'd0,   32'h0,        32'h6,    1'b0};
        vecs[10] = '{1'b0, 10'd5,   32'h0,        32'h0,    1'b1};
        vecs[11] = '{1'b1, 10'd4,   32'hFFFFFFFF, 32'h0,    1'b1};
        vecs[12] = '{1'b1, 10'h3FF, 32'hFFFFFFFF, 32'h0,    1'b1};
        vecs[13] = '{1'b0, 10'd0,   32'h0,        32'h6,    1'b0};
        vecs[14] = '{1'b0, 10'd3,   32'h0,        32'h0,    1'b0};
        vecs[15] = '{1'b1, 10'd0,   32'h0,        32'h0,    1'b0};
        vecs[16] = '{1'b1, 10'd1,   32'h0,        32'h0,    1'b0};
        vecs[17] = '{1'b1, 10'd2,   32'h0,        32'h0,    1'b0};
        vecs[18] = '{1'b0, 10'd0,   32'h0,        32'h0,    1'b0};

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 10'd0; PWDATA = 32'd0; EXTIN = 1'b0;
        #1;
        checkOutput("rst_tick", {31'd0, TICKOUT}, 32'd0);
        checkOutput("rst_filt", {31'd0, FILTLVL}, 32'd0);
        checkOutput("rst_prdata_idle", PRDATA, 32'd0);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            checkOutput($sformatf("vec%0d_data", i), rd, vecs[i].expData);
            checkOutput($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].expErr});
        end

        // Rising-edge source, F=0, P=0, EXTIN period 4.
        settle(4);
        apbWrite(10'd1, 32'd0);
        apbWrite(10'd2, 32'd0);
        apbWrite(10'd0, 32'd1);
        runModel(24, 4, 2'b00, 16'd0, "rise", ticks);
        checkOutput("rise_ticks", ticks, 32'd6);

        // Both edges, P=9: tick every 20 cycles.
        settle(6);
        apbWrite(10'd2, 32'd9);
        apbWrite(10'd0, 32'd5);
        runModel(60, 4, 2'b10, 16'd9, "both", ticks);
        checkOutput("both_ticks", ticks, 32'd2);

        // Every-PCLK source, P=4, then PRESC=1 written mid-count.
        settle(6);
        apbWrite(10'd2, 32'd4);
        apbWrite(10'd0, 32'd7);
        runModel(12, 4, 2'b11, 16'd4, "clk", ticks);
        checkOutput("clk_ticks", ticks, 32'd2);
        EXTIN = 1'b0;
        apbWrite(10'd2, 32'd1);
        PSEL = 1'b1; PADDR = 10'd3; PWRITE = 1'b0;
        #1;
        checkOutput("presc_wr_cnt", {16'd0, PRDATA[31:16]}, 32'd0);
        checkOutput("presc_wr_tick", {31'd0, TICKOUT}, 32'd0);
        @(negedge PCLK);
        checkOutput("presc_p1_tick", {31'd0, TICKOUT}, 32'd0);
        checkOutput("presc_p1_cnt", {16'd0, PRDATA[31:16]}, 32'd1);
        @(negedge PCLK);
        checkOutput("presc_p2_tick", {31'd0, TICKOUT}, 32'd1);
        checkOutput("presc_p2_cnt", {16'd0, PRDATA[31:16]}, 32'd0);
        PSEL = 1'b0;

        // W1C racing a tick keeps TICKSEEN; W1C with no ticks clears it.
        apbWrite(10'd3, 32'd1);
        PSEL = 1'b1; PADDR = 10'd3; PWRITE = 1'b0;
        #1;
        checkOutput("w1c_vs_tick", {31'd0, PRDATA[0]}, 32'd1);
        @(negedge PCLK);
        PSEL = 1'b0;
        apbWrite(10'd0, 32'd0);
        apbWrite(10'd3, 32'd1);
        applyStimulus(1'b0, 10'd3, 32'd0, rd, err);
        checkOutput("w1c_clear", rd, 32'd0);

        // Glitch filter F=3: 2-cycle glitch rejected, 5-cycle pulse passes.
        settle(4);
        apbWrite(10'd1, 32'd3);
        apbWrite(10'd2, 32'd0);
        apbWrite(10'd0, 32'd1);
        EXTIN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge PCLK);
            if (k == 2) EXTIN = 1'b0;
            checkOutput($sformatf("glitch_filt_%0d", k), {31'd0, FILTLVL}, 32'd0);
            checkOutput($sformatf("glitch_tick_%0d", k), {31'd0, TICKOUT}, 32'd0);
        end
        EXTIN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge PCLK);
            if (k == 5) EXTIN = 1'b0;
            checkOutput($sformatf("pulse_filt_%0d", k), {31'd0, FILTLVL}, {31'd0, (k >= 6 && k <= 10)});
            checkOutput($sformatf("pulse_tick_%0d", k), {31'd0, TICKOUT}, {31'd0, (k == 7)});
        end

        // Reset mid-count with EXTIN high; no ticks until CTRL is rewritten.
        settle(4);
        apbWrite(10'd1, 32'd0);
        apbWrite(10'd2, 32'd9);
        apbWrite(10'd0, 32'd7);
        repeat (4) @(negedge PCLK);
        EXTIN = 1'b1;
        PRESETn = 1'b0;
        PSEL = 1'b1; PADDR = 10'd3; PWRITE = 1'b0;
        #1;
        checkOutput("midrst_tick", {31'd0, TICKOUT}, 32'd0);
        checkOutput("midrst_filt", {31'd0, FILTLVL}, 32'd0);
        checkOutput("midrst_status", PRDATA, 32'd0);
        PSEL = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b0, 10'(a), 32'd0, rd, err);
            checkOutput($sformatf("postrst_reg%0d", a), rd, 32'd0);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            checkOutput($sformatf("postrst_tick_%0d", k), {31'd0, TICKOUT}, 32'd0);
        end
        checkOutput("postrst_filt_high", {31'd0, FILTLVL}, 32'd1);
        apbWrite(10'd0, 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge PCLK);
            checkOutput($sformatf("enable_nospur_%0d", k), {31'd0, TICKOUT}, 32'd0);
        end
        EXTIN = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge PCLK);
            checkOutput($sformatf("fall_notick_%0d", k), {31'd0, TICKOUT}, 32'd0);
        end
        EXTIN = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge PCLK);
            checkOutput($sformatf("latency_tick_%0d", k), {31'd0, TICKOUT}, {31'd0, (k == 4)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
